lap_register: RTL

- Lap-time store that responds to the stopwatch control FSM's SAVE, RETRIEVE and CLEAR commands.
- Captures the current {hour, minute, second, m_sec} epoch into a small circular buffer.
- Plays entries back newest-first, one per retrieve command.
- Drives the reg_busy stimulus back to control_fsm; the FSM holds off new commands while busy=1.

---
 rtl/lap_register.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/lap_register.sv
// lap_register: circular lap-time store with newest-first playback for the stopwatch FSM.
// Macro LAP_OVERWRITE_EN: a save when full replaces the oldest lap; otherwise it is rejected and pulses overflow.
module lap_register #(
  parameter int DEPTH  = 8,
  parameter int TIME_W = 28,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              save,
  input  logic              retrieve,
  input  logic              clear,
  input  logic [TIME_W-1:0] time_in,
  output logic              busy,
  output logic [TIME_W-1:0] time_out,
  output logic              out_valid,
  output logic [PTR_W-1:0]  lap_index,
  output logic [PTR_W:0]    count,
  output logic              full,
  output logic              empty
`ifndef LAP_OVERWRITE_EN
  ,
  output logic              overflow
`endif
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WRITE     = 3'd1,
    READ      = 3'd2,
    READ_WAIT = 3'd3,
    CLR       = 3'd4
  } state_t;

  localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] PTR_LAST = {PTR_W{1'b1}};
  localparam logic [PTR_W:0]   CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_LAST = (PTR_W+1)'(DEPTH - 1);

  state_t              state_r;
  logic [TIME_W-1:0]   mem_r [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_r;
  logic [PTR_W-1:0]    rd_idx_r;
  logic [PTR_W-1:0]    clr_ptr_r;
  logic [PTR_W:0]      count_r;
  logic [TIME_W-1:0]   save_data_r;
  logic [TIME_W-1:0]   rd_data_r;
  logic [TIME_W-1:0]   time_out_r;
  logic [PTR_W-1:0]    lap_index_r;
  logic                busy_r;
  logic                out_valid_r;
  logic                full_r;
  logic                empty_r;
  logic [PTR_W-1:0]    rd_addr_s;
  logic                save_ok_s;
`ifndef LAP_OVERWRITE_EN
  logic                overflow_r;
`endif

  // Newest entry sits just behind wr_ptr; DEPTH is a power of two so the subtraction wraps for free.
  assign rd_addr_s = wr_ptr_r - PTR_ONE - rd_idx_r;

`ifdef LAP_OVERWRITE_EN
  assign save_ok_s = 1'b1;
`else
  assign save_ok_s = ~full_r;
`endif

  // Command FSM, lap memory and all registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= IDLE;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
      time_out_r  <= '0;
      lap_index_r <= '0;
      wr_ptr_r    <= '0;
      rd_idx_r    <= '0;
      clr_ptr_r   <= '0;
      count_r     <= '0;
      full_r      <= 1'b0;
      empty_r     <= 1'b1;
`ifndef LAP_OVERWRITE_EN
      overflow_r  <= 1'b0;
`endif
    end else begin
      out_valid_r <= 1'b0;
`ifndef LAP_OVERWRITE_EN
      overflow_r  <= 1'b0;
`endif
      case (state_r)
        IDLE: begin
          if (clear) begin
            state_r   <= CLR;
            busy_r    <= 1'b1;
            clr_ptr_r <= '0;
          end else if (save) begin
            if (save_ok_s) begin
              save_data_r <= time_in;
              state_r     <= WRITE;
              busy_r      <= 1'b1;
            end else begin
              state_r <= IDLE;
`ifndef LAP_OVERWRITE_EN
              overflow_r <= 1'b1;
`endif
            end
          end else if (retrieve) begin
            state_r <= READ;
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        WRITE: begin
          mem_r[wr_ptr_r] <= save_data_r;
          wr_ptr_r        <= wr_ptr_r + PTR_ONE;
          rd_idx_r        <= '0;
          if (!full_r) begin
            count_r <= count_r + CNT_ONE;
          end
          full_r  <= full_r | (count_r == CNT_LAST);
          empty_r <= 1'b0;
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        READ: begin
          rd_data_r <= empty_r ? '0 : mem_r[rd_addr_s];
          state_r   <= READ_WAIT;
        end
        READ_WAIT: begin
          time_out_r  <= rd_data_r;
          lap_index_r <= rd_idx_r;
          out_valid_r <= 1'b1;
          // Wrap back to the newest lap once every stored lap has been shown.
          if (({1'b0, rd_idx_r} + CNT_ONE) >= count_r) begin
            rd_idx_r <= '0;
          end else begin
            rd_idx_r <= rd_idx_r + PTR_ONE;
          end
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        CLR: begin
          mem_r[clr_ptr_r] <= '0;
          clr_ptr_r        <= clr_ptr_r + PTR_ONE;
          if (clr_ptr_r == PTR_LAST) begin
            state_r     <= IDLE;
            busy_r      <= 1'b0;
            wr_ptr_r    <= '0;
            rd_idx_r    <= '0;
            count_r     <= '0;
            full_r      <= 1'b0;
            empty_r     <= 1'b1;
            time_out_r  <= '0;
            lap_index_r <= '0;
          end else begin
            state_r <= CLR;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign time_out  = time_out_r;
  assign out_valid = out_valid_r;
  assign lap_index = lap_index_r;
  assign count     = count_r;
  assign full      = full_r;
  assign empty     = empty_r;
`ifndef LAP_OVERWRITE_EN
  assign overflow  = overflow_r;
`endif

endmodule
